ps2_char_keys: RTL and testbench

PS/2 keyboard front end that drives the character controller's movement inputs. It receives scan-code set 2 bytes from the keyboard pins and tracks make/break codes for the game keys. It presents held-key levels `stepleft`, `stepright` and `stepjump`, plus a one-cycle `start_pulse` for the game-state logic. It sits between the board PS/2 pins and the character control / game FSM, in the 65 MHz pixel-clock domain.

---
 rtl/ps2_char_keys.sv | 221 ++++++++++++++++++++++
 tb/tb_ps2_char_keys.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/ps2_char_keys.sv
// PS/2 set-2 keyboard front end: frame receiver, make/break decoder and held-key movement levels.
// Define ARROW_KEYS_EN to also decode the E0-prefixed arrow keys (left, right, up).
module ps2_char_keys #(
    parameter int unsigned CLK_HZ     = 65_000_000,
    parameter int unsigned TIMEOUT_US = 2000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic ps2_clk,
    input  logic ps2_data,
    output logic stepleft,
    output logic stepright,
    output logic stepjump,
    output logic start_pulse,
    output logic rx_err
);

    localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;
    localparam int unsigned TW          = $clog2(TIMEOUT_CYC + 1);

    localparam int unsigned K_A   = 0;
    localparam int unsigned K_D   = 1;
    localparam int unsigned K_W   = 2;
    localparam int unsigned K_SP  = 3;
    localparam int unsigned K_ENT = 4;
    localparam int unsigned K_LT  = 5;
    localparam int unsigned K_RT  = 6;
    localparam int unsigned K_UP  = 7;

    typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {D_NORM, D_BRK, D_EXT, D_EXT_BRK} dec_state_t;

    // Pin synchronisers; third ps2_clk flop gives the falling edge
    logic clk_s1, clk_s2, clk_s3, dat_s1, dat_s2;
    logic fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fall = ~clk_s2 & clk_s3;

    rx_state_t       rx_state, rx_next;
    logic [2:0]      bit_cnt, bit_cnt_n;
    logic [7:0]      shreg, shreg_n;
    logic [TW-1:0]   tmo, tmo_n;
    logic            byte_stb, byte_stb_n, rx_err_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_state <= RX_IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            tmo      <= TW'(0);
            byte_stb <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_state <= rx_next;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            tmo      <= tmo_n;
            byte_stb <= byte_stb_n;
            rx_err   <= rx_err_n;
        end
    end

    // Receiver: a fall always wins over a coincident timeout expiry
    always_comb begin
        rx_next    = rx_state;
        bit_cnt_n  = bit_cnt;
        shreg_n    = shreg;
        tmo_n      = tmo;
        byte_stb_n = 1'b0;
        rx_err_n   = 1'b0;
        if (rx_state != RX_IDLE)
            tmo_n = tmo + TW'(1);
        if (fall) begin
            tmo_n = TW'(0);
            unique case (rx_state)
                RX_IDLE: begin
                    if (!dat_s2) begin
                        rx_next   = RX_DATA;
                        bit_cnt_n = 3'd0;
                    end
                end
                RX_DATA: begin
                    shreg_n   = {dat_s2, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7)
                        rx_next = RX_PARITY;
                end
                RX_PARITY: begin
                    if (^{shreg, dat_s2}) begin
                        rx_next = RX_STOP;
                    end else begin
                        rx_next  = RX_IDLE;
                        rx_err_n = 1'b1;
                    end
                end
                RX_STOP: begin
                    rx_next    = RX_IDLE;
                    byte_stb_n = dat_s2;
                    rx_err_n   = ~dat_s2;
                end
                default: rx_next = RX_IDLE;
            endcase
        end else if (rx_state != RX_IDLE && tmo == TW'(TIMEOUT_CYC - 1)) begin
            rx_next  = RX_IDLE;
            rx_err_n = 1'b1;
            tmo_n    = TW'(0);
        end
    end

    function automatic logic [7:0] key_update(input logic [7:0] cur, input logic [7:0] code,
                                              input logic ext, input logic val);
        key_update = cur;
        if (!ext) begin
            unique case (code)
                8'h1C:   key_update[K_A]   = val;
                8'h23:   key_update[K_D]   = val;
                8'h1D:   key_update[K_W]   = val;
                8'h29:   key_update[K_SP]  = val;
                8'h5A:   key_update[K_ENT] = val;
                default: key_update        = cur;
            endcase
        end else begin
`ifdef ARROW_KEYS_EN
            unique case (code)
                8'h6B:   key_update[K_LT] = val;
                8'h74:   key_update[K_RT] = val;
                8'h75:   key_update[K_UP] = val;
                default: key_update       = cur;
            endcase
`else
            key_update = cur;
`endif
        end
    endfunction

    dec_state_t dec_state, dec_next;
    logic [7:0] keys, keys_n;
    logic       is_pfx, ent_prev;

    assign is_pfx = (shreg == 8'hE0) || (shreg == 8'hF0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_state <= D_NORM;
            keys      <= 8'd0;
        end else begin
            dec_state <= dec_next;
            keys      <= keys_n;
        end
    end

    // Decoder: prefixes arriving inside a break sequence abort it
    always_comb begin
        dec_next = dec_state;
        keys_n   = keys;
        if (byte_stb) begin
            unique case (dec_state)
                D_NORM: begin
                    if (shreg == 8'hF0)      dec_next = D_BRK;
                    else if (shreg == 8'hE0) dec_next = D_EXT;
                    else                     keys_n = key_update(keys, shreg, 1'b0, 1'b1);
                end
                D_BRK: begin
                    dec_next = D_NORM;
                    if (!is_pfx) keys_n = key_update(keys, shreg, 1'b0, 1'b0);
                end
                D_EXT: begin
                    if (shreg == 8'hF0) begin
                        dec_next = D_EXT_BRK;
                    end else begin
                        dec_next = D_NORM;
                        keys_n   = key_update(keys, shreg, 1'b1, 1'b1);
                    end
                end
                D_EXT_BRK: begin
                    dec_next = D_NORM;
                    if (!is_pfx) keys_n = key_update(keys, shreg, 1'b1, 1'b0);
                end
                default: dec_next = D_NORM;
            endcase
        end
    end

    logic l_held, r_held;
    assign l_held = keys[K_A] | keys[K_LT];
    assign r_held = keys[K_D] | keys[K_RT];

    // Enter pulses only on the 0->1 transition of its key bit, so repeats are silent
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stepleft    <= 1'b0;
            stepright   <= 1'b0;
            stepjump    <= 1'b0;
            start_pulse <= 1'b0;
            ent_prev    <= 1'b0;
        end else begin
            stepleft    <= l_held & ~r_held;
            stepright   <= r_held & ~l_held;
            stepjump    <= keys[K_W] | keys[K_SP] | keys[K_UP];
            start_pulse <= keys[K_ENT] & ~ent_prev;
            ent_prev    <= keys[K_ENT];
        end
    end

endmodule

// File: tb/tb_ps2_char_keys.sv
// Directed bench for ps2_char_keys: frames driven on the PS/2 pins, levels and pulses checked.
module tb_ps2_char_keys;

    localparam int unsigned CLK_HZ      = 1_000_000;
    localparam int unsigned TIMEOUT_US  = 200;
    localparam int unsigned TIMEOUT_CYC = CLK_HZ / 1_000_000 * TIMEOUT_US;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2_clk = 1'b1;
    logic ps2_data = 1'b1;
    logic stepleft, stepright, stepjump, start_pulse, rx_err;

    int n_cmp = 0;
    int n_bad = 0;
    int err_cnt = 0;
    int sp_cnt = 0;
    logic err_long = 1'b0;
    logic sp_long = 1'b0;
    logic err_q = 1'b0;
    logic sp_q = 1'b0;

    ps2_char_keys #(.CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US)) dut (
        .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .stepleft(stepleft), .stepright(stepright), .stepjump(stepjump),
        .start_pulse(start_pulse), .rx_err(rx_err)
    );

    always #5 clk = ~clk;

    // Pulse counters and width watchers
    always @(posedge clk) begin
        err_q <= rx_err;
        sp_q  <= start_pulse;
        if (rx_err) err_cnt <= err_cnt + 1;
        if (start_pulse) sp_cnt <= sp_cnt + 1;
        if (rx_err && err_q) err_long <= 1'b1;
        if (start_pulse && sp_q) sp_long <= 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One PS/2 bit; with lat set, stepleft is checked at the 4th and 5th clk after the low sample
    task automatic ps2_bit(input logic b, input bit lat);
        @(negedge clk) ps2_data = b;
        repeat (4) @(negedge clk);
        ps2_clk = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge clk);
            #1;
            if (lat && i == 4) check("lat_before", 32'(stepleft), 32'd0);
            if (lat && i == 5) check("lat_after", 32'(stepleft), 32'd1);
        end
        @(negedge clk) ps2_clk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] code, input bit bad_par, input bit lat);
        logic par;
        par = ~^code;
        if (bad_par) par = ~par;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i], 1'b0);
        ps2_bit(par, 1'b0);
        ps2_bit(1'b1, lat);
        repeat (10) @(negedge clk);
    endtask

    task automatic send_ok(input logic [7:0] code);
        send(code, 1'b0, 1'b0);
    endtask

    initial begin
        int e0;
        int waited;
        logic [7:0] partial;
        partial = 8'h1D;

        repeat (3) @(negedge clk);
        #1;
        check("rst_left", 32'(stepleft), 32'd0);
        check("rst_right", 32'(stepright), 32'd0);
        check("rst_jump", 32'(stepjump), 32'd0);
        check("rst_start", 32'(start_pulse), 32'd0);
        check("rst_err", 32'(rx_err), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // A make with latency, then break
        send(8'h1C, 1'b0, 1'b1);
        check("a_left", 32'(stepleft), 32'd1);
        check("a_right", 32'(stepright), 32'd0);
        check("a_jump", 32'(stepjump), 32'd0);
        send_ok(8'hF0); send_ok(8'h1C);
        check("a_brk_left", 32'(stepleft), 32'd0);

        // A and D held cancel
        send_ok(8'h1C); send_ok(8'h23);
        check("ad_left", 32'(stepleft), 32'd0);
        check("ad_right", 32'(stepright), 32'd0);
        send_ok(8'hF0); send_ok(8'h1C);
        check("d_right", 32'(stepright), 32'd1);
        send_ok(8'hF0); send_ok(8'h23);
        check("d_brk_right", 32'(stepright), 32'd0);

        // Extended right arrow
        send_ok(8'hE0); send_ok(8'h74);
`ifdef ARROW_KEYS_EN
        check("ext_right", 32'(stepright), 32'd1);
`else
        check("ext_right", 32'(stepright), 32'd0);
`endif
        send_ok(8'h29);
        check("sp_jump", 32'(stepjump), 32'd1);
        send_ok(8'hE0); send_ok(8'hF0); send_ok(8'h74);
        check("ext_brk_right", 32'(stepright), 32'd0);
        send_ok(8'hF0); send_ok(8'h29);
        check("sp_brk_jump", 32'(stepjump), 32'd0);

        // Bad parity
        e0 = err_cnt;
        send(8'h29, 1'b1, 1'b0);
        check("par_err_cnt", 32'(err_cnt - e0), 32'd1);
        check("par_jump", 32'(stepjump), 32'd0);
        send_ok(8'h29);
        check("par_recover_jump", 32'(stepjump), 32'd1);
        send_ok(8'hF0); send_ok(8'h29);
        check("par_brk_jump", 32'(stepjump), 32'd0);

        // Timeout after 5 data bits
        e0 = err_cnt;
        ps2_bit(1'b0, 1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(partial[i], 1'b0);
        waited = 0;
        while (err_cnt == e0 && waited < int'(TIMEOUT_CYC) + 40) begin
            @(negedge clk);
            waited++;
        end
        check("tmo_err_cnt", 32'(err_cnt - e0), 32'd1);
        repeat (5) @(negedge clk);
        send_ok(8'h1D);
        check("tmo_recover_jump", 32'(stepjump), 32'd1);
        send_ok(8'hF0); send_ok(8'h1D);
        check("tmo_brk_jump", 32'(stepjump), 32'd0);

        // Reset mid-frame discards the partial byte
        ps2_bit(1'b0, 1'b0);
        ps2_bit(1'b1, 1'b0);
        ps2_bit(1'b1, 1'b0);
        @(negedge clk) rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_ok(8'h23);
        check("rst_mid_right", 32'(stepright), 32'd1);
        send_ok(8'hF0); send_ok(8'h23);

        // Enter typematic: two pulses only
        e0 = sp_cnt;
        send_ok(8'h5A); send_ok(8'h5A); send_ok(8'h5A);
        send_ok(8'hF0); send_ok(8'h5A);
        send_ok(8'h5A);
        check("start_cnt", 32'(sp_cnt - e0), 32'd2);
        check("start_width", 32'(sp_long), 32'd0);
        check("err_width", 32'(err_long), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
